// File: rtl/fuzz_sig_collector.sv
// fuzz_sig_collector: folds each qualified 245-bit result sample into a 32-bit MISR and
// freezes the signature after SAMPLES accepted samples for comparison against exp_sig.
module fuzz_sig_collector #(
  parameter int               Y_W     = 245,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED    = 32'hFFFFFFFF,
  parameter int               SAMPLES = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Y_W-1:0]   y_in,
  input  logic             y_valid,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic [7:0]       sample_cnt,
  output logic [SIG_W-1:0] sig_out,
  output logic             match
);

  localparam int         N_SLICE  = (Y_W + SIG_W - 1) / SIG_W;
  localparam logic [7:0] LAST_CNT = 8'(SAMPLES - 1);

  // One-hot so busy/done come straight from flops
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_load;
  logic             w_last;

  function automatic logic [SIG_W-1:0] fold_f(input logic [Y_W-1:0] y);
    logic [N_SLICE*SIG_W-1:0] pad;
    logic [SIG_W-1:0]         acc;
    pad          = {(N_SLICE*SIG_W){1'b0}};
    pad[Y_W-1:0] = y;
    acc          = {SIG_W{1'b0}};
    for (int i = 0; i < N_SLICE; i++) begin
      acc = acc ^ pad[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] fold);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ fold;
  endfunction

  assign w_accept = (r_state == ST_RUN) && y_valid;
  assign w_last   = (r_cnt == LAST_CNT);
  // start is honoured from IDLE and DONE only; a restart mid-run is dropped
  assign w_load   = start && (r_state != ST_RUN);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sig   <= {SIG_W{1'b0}};
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_accept && w_last) w_state_nxt = ST_DONE;
        else                    w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Signature and sample counter update
  always_comb begin
    w_sig_nxt = r_sig;
    w_cnt_nxt = r_cnt;
    if (w_load) begin
      w_sig_nxt = SEED;
      w_cnt_nxt = 8'd0;
    end else if (w_accept) begin
      w_sig_nxt = misr_step(r_sig, fold_f(y_in));
      w_cnt_nxt = r_cnt + 8'd1;
    end else begin
      w_sig_nxt = r_sig;
      w_cnt_nxt = r_cnt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_cnt = r_cnt;
  assign sig_out    = r_sig;
  assign match      = r_done && (r_sig == exp_sig);

endmodule

// File: tb/tb_fuzz_sig_collector.sv
// Scoreboard bench for fuzz_sig_collector: four instances with different SEED/SAMPLES,
// expected final signatures queued at stimulus time and popped when done rises.
module tb_fuzz_sig_collector;

  localparam logic [31:0] POLY         = 32'h04C11DB7;
  localparam logic [31:0] SEED_TAB [4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam int          SAMP_TAB [4] = '{1, 1, 4, 21};

  typedef struct {
    logic [31:0] sig;
    logic [7:0]  cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_v [4];
  logic [244:0] y_v     [4];
  logic         yv_v    [4];
  logic [31:0]  exp_v   [4];
  logic         busy_v  [4];
  logic         done_v  [4];
  logic         match_v [4];
  logic [7:0]   cnt_v   [4];
  logic [31:0]  sig_v   [4];
  logic         done_prev [4] = '{default: 1'b0};
  exp_t         exp_q [4][$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fuzz_sig_collector #(
      .SEED    (SEED_TAB[g]),
      .SAMPLES (SAMP_TAB[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[g]),
      .y_in       (y_v[g]),
      .y_valid    (yv_v[g]),
      .exp_sig    (exp_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .sample_cnt (cnt_v[g]),
      .sig_out    (sig_v[g]),
      .match      (match_v[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input int g, input string tag, input logic b, input logic d,
                           input logic [7:0] c);
    chk({tag, "_busy"}, {31'd0, busy_v[g]}, {31'd0, b});
    chk({tag, "_done"}, {31'd0, done_v[g]}, {31'd0, d});
    chk({tag, "_cnt"},  {24'd0, cnt_v[g]},  {24'd0, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference fold written bit-by-bit: bit b of y lands on signature bit b mod 32
  function automatic logic [31:0] m_fold(input logic [244:0] y);
    logic [31:0] f;
    f = 32'd0;
    for (int b = 0; b < 245; b++) f[b % 32] = f[b % 32] ^ y[b];
    return f;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [244:0] y);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'd0) ^ m_fold(y);
  endfunction

  function automatic logic [244:0] mk_y(input logic [31:0] w);
    logic [255:0] t;
    t = {8{w}};
    return t[244:0];
  endfunction

  // Monitor: pop the expected final signature whenever an instance completes
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (done_v[g] && !done_prev[g]) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut%0d: got done=1 required no completion", g);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("final_sig_dut%0d", g), sig_v[g], e.sig);
          chk($sformatf("final_cnt_dut%0d", g), {24'd0, cnt_v[g]}, {24'd0, e.cnt});
        end
      end
      done_prev[g] <= done_v[g];
    end
  end

  initial begin
    logic [244:0] all1;
    logic [244:0] bvec [3];
    logic [31:0]  bexp [3];
    logic [31:0]  m;
    logic [31:0]  md;
    int           pat  [7];
    int           cexp [7];

    all1 = '1;
    for (int g = 0; g < 4; g++) begin
      start_v[g] = 1'b0;
      yv_v[g]    = 1'b0;
      y_v[g]     = '0;
      exp_v[g]   = 32'd0;
    end

    // Reset values on every instance
    #1 rst_n = 1'b0;
    #3;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_sig_dut%0d", g), sig_v[g], 32'd0);
      chk_state(g, $sformatf("rst_dut%0d", g), 1'b0, 1'b0, 8'd0);
      chk($sformatf("rst_match_dut%0d", g), {31'd0, match_v[g]}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();

    // A: SEED=FFFFFFFF, SAMPLES=1, zero sample
    exp_q[0].push_back('{32'hFB3EE249, 8'd1});
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    chk_state(0, "a_start", 1'b1, 1'b0, 8'd0);
    chk("a_start_sig", sig_v[0], 32'hFFFFFFFF);
    y_v[0] = '0; yv_v[0] = 1'b1; tick(); yv_v[0] = 1'b0;
    chk_state(0, "a_done", 1'b0, 1'b1, 8'd1);
    y_v[0] = all1; yv_v[0] = 1'b1; tick(); yv_v[0] = 1'b0;
    chk("a_done_ignore_sig", sig_v[0], 32'hFB3EE249);
    chk_state(0, "a_done_ignore", 1'b0, 1'b1, 8'd1);
    start_v[0] = 1'b1; yv_v[0] = 1'b1; tick(); start_v[0] = 1'b0; yv_v[0] = 1'b0;
    chk_state(0, "a_restart", 1'b1, 1'b0, 8'd0);
    chk("a_restart_sig", sig_v[0], 32'hFFFFFFFF);
    exp_q[0].push_back('{32'hFB3EE249, 8'd1});
    y_v[0] = '0; yv_v[0] = 1'b1; tick(); yv_v[0] = 1'b0;
    chk_state(0, "a_redone", 1'b0, 1'b1, 8'd1);

    // B: SEED=0 fold coverage, preceded by y_valid in IDLE
    y_v[1] = all1; yv_v[1] = 1'b1; tick(); yv_v[1] = 1'b0;
    chk("b_idle_sig", sig_v[1], 32'd0);
    chk_state(1, "b_idle", 1'b0, 1'b0, 8'd0);
    bvec[0] = '0; bvec[0][224] = 1'b1;                  bexp[0] = 32'h00000001;
    bvec[1] = '0; bvec[1][0] = 1'b1; bvec[1][32] = 1'b1; bexp[1] = 32'h00000000;
    bvec[2] = '0; bvec[2][244] = 1'b1;                  bexp[2] = 32'h00100000;
    for (int k = 0; k < 3; k++) begin
      exp_q[1].push_back('{bexp[k], 8'd1});
      start_v[1] = 1'b1; tick(); start_v[1] = 1'b0;
      y_v[1] = bvec[k]; yv_v[1] = 1'b1; tick(); yv_v[1] = 1'b0;
      chk_state(1, $sformatf("b_fold%0d", k), 1'b0, 1'b1, 8'd1);
    end

    // C: SAMPLES=4 with valid gaps and a start pulse mid-run
    pat  = '{1, 0, 0, 1, 1, 0, 1};
    cexp = '{1, 1, 1, 2, 3, 3, 4};
    m = 32'hFFFFFFFF;
    for (int k = 0; k < 7; k++) if (pat[k] != 0) m = m_step(m, mk_y(32'h13579BDF + k));
    exp_q[2].push_back('{m, 8'd4});
    start_v[2] = 1'b1; tick(); start_v[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      y_v[2]     = mk_y(32'h13579BDF + k);
      yv_v[2]    = (pat[k] != 0);
      start_v[2] = (k == 2);
      tick();
      chk_state(2, $sformatf("c_edge%0d", k + 1), (k != 6), (k == 6), 8'(cexp[k]));
    end
    start_v[2] = 1'b0; yv_v[2] = 1'b0;

    // D: SAMPLES=21, two identical runs, match against model signature
    md = 32'hFFFFFFFF;
    for (int i = 0; i < 21; i++) md = m_step(md, mk_y(32'(32'h9E3779B9 * (i + 1))));
    exp_v[3] = ~md;
    for (int r = 0; r < 2; r++) begin
      exp_q[3].push_back('{md, 8'd21});
      start_v[3] = 1'b1; tick(); start_v[3] = 1'b0;
      chk_state(3, $sformatf("d_run%0d_start", r), 1'b1, 1'b0, 8'd0);
      chk($sformatf("d_run%0d_match_busy", r), {31'd0, match_v[3]}, 32'd0);
      for (int i = 0; i < 21; i++) begin
        y_v[3] = mk_y(32'(32'h9E3779B9 * (i + 1))); yv_v[3] = 1'b1; tick();
        if (i == 19) chk_state(3, $sformatf("d_run%0d_pre", r), 1'b1, 1'b0, 8'd20);
      end
      yv_v[3] = 1'b0;
      chk_state(3, $sformatf("d_run%0d_done", r), 1'b0, 1'b1, 8'd21);
      if (r == 0) begin
        chk("d_run0_mismatch", {31'd0, match_v[3]}, 32'd0);
        exp_v[3] = md; #1;
        chk("d_run0_match", {31'd0, match_v[3]}, 32'd1);
      end else begin
        chk("d_run1_match", {31'd0, match_v[3]}, 32'd1);
        exp_v[3][0] = ~exp_v[3][0]; #1;
        chk("d_run1_flip", {31'd0, match_v[3]}, 32'd0);
        exp_v[3][0] = ~exp_v[3][0]; #1;
        chk("d_run1_restore", {31'd0, match_v[3]}, 32'd1);
      end
    end

    // Mid-run reset after 3 samples
    tick();
    start_v[3] = 1'b1; tick(); start_v[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_v[3] = mk_y(32'hA5A5A5A5 + i); yv_v[3] = 1'b1; tick();
    end
    yv_v[3] = 1'b0;
    chk_state(3, "e_three", 1'b1, 1'b0, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_sig", sig_v[3], 32'd0);
    chk_state(3, "e_rst", 1'b0, 1'b0, 8'd0);
    chk("e_rst_match", {31'd0, match_v[3]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    yv_v[3] = 1'b1; tick(); tick(); yv_v[3] = 1'b0;
    chk("e_idle_sig", sig_v[3], 32'd0);
    chk_state(3, "e_idle", 1'b0, 1'b0, 8'd0);
    start_v[3] = 1'b1; tick(); start_v[3] = 1'b0;
    chk_state(3, "e_restart", 1'b1, 1'b0, 8'd0);
    chk("e_restart_sig", sig_v[3], 32'hFFFFFFFF);

    // Every queued completion must have been observed
    tick(); tick();
    for (int g = 0; g < 4; g++) chk($sformatf("pending_dut%0d", g), exp_q[g].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
